// File: rtl/vx_tcu_multi_top.sv
// Multi-unit tensor-core top: warp-id steering to NUM_UNITS engines, round-robin result merge.
// Optional perf counters enabled by defining VX_TCU_MULTI_PERF_EN.

module vx_tcu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_cnt == CNT_W'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_data    = r_mem[r_rd];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) r_wr <= ptr_inc(r_wr);
            if (w_pop_ok)  r_rd <= ptr_inc(r_rd);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// Single-stage engine: result is the bitwise complement of the resized payload.
module VX_tcu_core #(
    parameter int EXEC_W   = 256,
    parameter int RESULT_W = 256
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_execute_valid,
    input  logic [EXEC_W-1:0]   i_execute_data,
    output logic                o_execute_ready,
    output logic                o_result_valid,
    output logic [RESULT_W-1:0] o_result_data,
    input  logic                i_result_ready
);
    logic                r_valid;
    logic [RESULT_W-1:0] r_data;

    assign o_execute_ready = !r_valid || i_result_ready;
    assign o_result_valid  = r_valid;
    assign o_result_data   = r_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_execute_ready) begin
            r_valid <= i_execute_valid;
            if (i_execute_valid) r_data <= ~RESULT_W'(i_execute_data);
        end
    end
endmodule

module vx_tcu_multi_top #(
    parameter int NUM_UNITS    = 2,
    parameter int EXEC_W       = 256,
    parameter int RESULT_W     = 256,
    parameter int WID_W        = 4,
    parameter int IN_DEPTH     = 2,
    parameter int OUT_DEPTH    = 4,
    parameter int MAX_INFLIGHT = 4,
    localparam int UNIT_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_execute_valid,
    input  logic [WID_W-1:0]    i_execute_wid,
    input  logic [EXEC_W-1:0]   i_execute_data,
    output logic                o_execute_ready,
    output logic                o_result_valid,
    output logic [RESULT_W-1:0] o_result_data,
    output logic [UNIT_W-1:0]   o_result_unit,
    input  logic                i_result_ready,
`ifdef VX_TCU_MULTI_PERF_EN
    output logic [31:0]         o_perf_stall_cycles,
    output logic [31:0]         o_perf_issued,
`endif
    output logic                o_busy
);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [UNIT_W-1:0]   w_tgt;
    logic                w_accept;
    logic                w_fire;
    logic                w_any;
    logic                w_unused_wid;
    logic [NUM_UNITS-1:0] w_cap, w_push, w_pop, w_busy_vec;
    logic [NUM_UNITS-1:0] w_in_full, w_in_empty, w_core_rdy, w_core_vld, w_out_full, w_out_empty;
    logic [EXEC_W-1:0]   w_in_data   [NUM_UNITS];
    logic [RESULT_W-1:0] w_core_data [NUM_UNITS];
    logic [RESULT_W-1:0] w_out_data  [NUM_UNITS];
    logic [CNT_W-1:0]    r_inflight  [NUM_UNITS];
    logic [UNIT_W-1:0]   r_grant, r_hold_unit, w_rr_unit, w_winner;
    logic                r_hold;

    assign w_unused_wid = ^i_execute_wid;

    generate
        if (NUM_UNITS > 1) begin : g_steer
            assign w_tgt = i_execute_wid[UNIT_W-1:0];
        end else begin : g_single
            assign w_tgt = '0;
        end
    endgenerate

    always_comb begin
        w_cap = '0;
        for (int u = 0; u < NUM_UNITS; u++)
            w_cap[u] = !w_in_full[u] && (r_inflight[u] < CNT_W'(MAX_INFLIGHT));
    end

    assign o_execute_ready = !i_reset && w_cap[w_tgt];
    assign w_accept        = i_execute_valid && o_execute_ready;

    generate
        for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
            logic w_inc, w_dec;
            assign w_push[u]     = w_accept && (w_tgt == UNIT_W'(u));
            assign w_pop[u]      = w_fire && (w_winner == UNIT_W'(u));
            assign w_inc         = w_push[u];
            assign w_dec         = w_pop[u];
            assign w_busy_vec[u] = (r_inflight[u] != '0);

            vx_tcu_fifo #(.W(EXEC_W), .DEPTH(IN_DEPTH)) u_in_buf (
                .i_clk, .i_reset,
                .i_push  (w_push[u]),
                .i_data  (i_execute_data),
                .i_pop   (w_core_rdy[u]),
                .o_data  (w_in_data[u]),
                .o_full  (w_in_full[u]),
                .o_empty (w_in_empty[u])
            );

            VX_tcu_core #(.EXEC_W(EXEC_W), .RESULT_W(RESULT_W)) u_core (
                .i_clk, .i_reset,
                .i_execute_valid (!w_in_empty[u]),
                .i_execute_data  (w_in_data[u]),
                .o_execute_ready (w_core_rdy[u]),
                .o_result_valid  (w_core_vld[u]),
                .o_result_data   (w_core_data[u]),
                .i_result_ready  (!w_out_full[u])
            );

            vx_tcu_fifo #(.W(RESULT_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
                .i_clk, .i_reset,
                .i_push  (w_core_vld[u]),
                .i_data  (w_core_data[u]),
                .i_pop   (w_pop[u]),
                .o_data  (w_out_data[u]),
                .o_full  (w_out_full[u]),
                .o_empty (w_out_empty[u])
            );

            always_ff @(posedge i_clk) begin
                if (i_reset) r_inflight[u] <= '0;
                else if (w_inc && !w_dec) r_inflight[u] <= r_inflight[u] + 1'b1;
                else if (w_dec && !w_inc) r_inflight[u] <= r_inflight[u] - 1'b1;
            end

            always_ff @(posedge i_clk) begin
                if (!i_reset) begin
                    assert (!(w_inc && !w_dec && r_inflight[u] == CNT_W'(MAX_INFLIGHT)));
                    assert (!(w_dec && !w_inc && r_inflight[u] == '0));
                end
            end
        end
    endgenerate

    // Lowest offset from the grant pointer wins; iterate downward so it is assigned last.
    always_comb begin
        w_rr_unit = r_grant;
        for (int i = NUM_UNITS - 1; i >= 0; i--)
            if (!w_out_empty[(int'(r_grant) + i) % NUM_UNITS])
                w_rr_unit = UNIT_W'((int'(r_grant) + i) % NUM_UNITS);
    end

    assign w_any          = !(&w_out_empty);
    assign w_winner       = r_hold ? r_hold_unit : w_rr_unit;
    assign o_result_valid = !i_reset && w_any;
    assign o_result_data  = o_result_valid ? w_out_data[w_winner] : '0;
    assign o_result_unit  = o_result_valid ? w_winner : '0;
    assign w_fire         = o_result_valid && i_result_ready;
    assign o_busy         = !i_reset && (|w_busy_vec);

    // A stalled offer is locked so a newly non-empty unit cannot retract it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_grant     <= '0;
            r_hold      <= 1'b0;
            r_hold_unit <= '0;
        end else begin
            r_hold      <= o_result_valid && !i_result_ready;
            r_hold_unit <= w_winner;
            if (w_fire) r_grant <= UNIT_W'((int'(w_winner) + 1) % NUM_UNITS);
        end
    end

`ifdef VX_TCU_MULTI_PERF_EN
    logic [31:0] r_perf_stall, r_perf_issued;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_perf_stall  <= '0;
            r_perf_issued <= '0;
        end else begin
            if (i_execute_valid && !o_execute_ready && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 1'b1;
            if (w_accept && r_perf_issued != '1)
                r_perf_issued <= r_perf_issued + 1'b1;
        end
    end
    assign o_perf_stall_cycles = r_perf_stall;
    assign o_perf_issued       = r_perf_issued;
`endif
endmodule
